// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 slice datapath.
// Contents:
//   DATA_W  - width of the X/Z/P data path
//   OPM_SUB - OPMODE bit that selects subtract in the post-adder
//   data_t  - 48-bit data word shared by the X/Z muxes and the post-adder
//   ext_t   - data word plus one carry bit
package dsp48a1_pkg;

    localparam int unsigned DATA_W  = 48;
    localparam int unsigned OPM_SUB = 7;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [DATA_W:0]   ext_t;

endpackage : dsp48a1_pkg

// File: rtl/post_adder_preg_if.sv
// Bus bundle between the X/Z multiplexers and the post-adder / P register stage.
// Signals:
//   x_in, z_in  - X and Z multiplexer outputs (48 bits)
//   cin         - carry-in, already registered/selected upstream
//   sub         - OPMODE[OPM_SUB]: 0 = add, 1 = subtract
//   cep         - clock enable for the P register
//   cecarryout  - clock enable for the carry-out register
//   p, pcout    - result and its cascade copy
//   carryout, carryoutf - carry/borrow out and its fabric copy
// Modports: master drives operands/enables, slave (the post-adder) drives results.
interface post_adder_preg_if;
    import dsp48a1_pkg::*;

    data_t x_in;
    data_t z_in;
    logic  cin;
    logic  sub;
    logic  cep;
    logic  cecarryout;
    data_t p;
    data_t pcout;
    logic  carryout;
    logic  carryoutf;

    modport master (
        output x_in, z_in, cin, sub, cep, cecarryout,
        input  p, pcout, carryout, carryoutf
    );

    modport slave (
        input  x_in, z_in, cin, sub, cep, cecarryout,
        output p, pcout, carryout, carryoutf
    );

endinterface : post_adder_preg_if

// File: rtl/reg_ce_rst.sv
// Generic pipeline register used throughout the slice.
// Parameters:
//   Width - data width
//   Reg   - 1 = registered, 0 = combinational pass-through
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, priority over ce
//   ce    - clock enable
//   d     - data in
//   q     - data out
module reg_ce_rst #(
    parameter int unsigned Width = 1,
    parameter bit          Reg   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    if (Reg) begin : gen_reg
        logic [Width-1:0] q_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q_q <= '0;
            end else if (ce) begin
                q_q <= d;
            end
        end

        assign q = q_q;
    end else begin : gen_bypass
        // Clock, reset and enable are intentionally ignored in bypass mode.
        logic unused_ctrl;
        assign unused_ctrl = clk ^ rst_n ^ ce;
        assign q = d;
    end

endmodule : reg_ce_rst

// File: rtl/post_adder_preg.sv
// Post-adder/subtractor and P-output register stage of the DSP48A1 slice.
// Computes Z +/- (X + CIN) on a 49-bit zero-extended datapath and drives the
// result through optional P and carry-out registers.
// Parameters:
//   PREG        - 1 = P/PCOUT registered (CEP-gated), 0 = combinational
//   CARRYOUTREG - 1 = CARRYOUT/CARRYOUTF registered (CECARRYOUT-gated), 0 = combinational
// Ports:
//   CLK   - rising-edge clock
//   RST_N - synchronous active-low reset for P and carry-out registers
//   bus   - slave side of post_adder_preg_if (operands, enables, results)
module post_adder_preg
    import dsp48a1_pkg::*;
#(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYOUTREG = 1'b1
) (
    input logic                     CLK,
    input logic                     RST_N,
    post_adder_preg_if.slave        bus
);

    ext_t  xs;
    ext_t  zs;
    ext_t  r;
    data_t sum;
    logic  cout;
    data_t p_q;
    logic  cout_q;

    assign xs = {1'b0, bus.x_in};
    assign zs = {1'b0, bus.z_in};

    // In subtract mode bit 48 of the modulo-2^49 difference is the borrow.
    assign r = bus.sub ? (zs - (xs + ext_t'(bus.cin)))
                       : (zs + xs + ext_t'(bus.cin));

    assign sum  = r[DATA_W-1:0];
    assign cout = r[DATA_W];

    reg_ce_rst #(
        .Width (DATA_W),
        .Reg   (PREG)
    ) u_preg (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (bus.cep),
        .d     (sum),
        .q     (p_q)
    );

    reg_ce_rst #(
        .Width (1),
        .Reg   (CARRYOUTREG)
    ) u_carryoutreg (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (bus.cecarryout),
        .d     (cout),
        .q     (cout_q)
    );

    // Each output pair comes from a single source so the copies cannot diverge.
    assign bus.p         = p_q;
    assign bus.pcout     = p_q;
    assign bus.carryout  = cout_q;
    assign bus.carryoutf = cout_q;

endmodule : post_adder_preg

// File: doc/post_adder_preg.md
# post_adder_preg

Post-adder/subtractor and P-output register stage of the DSP48A1 slice datapath. Consumes the 48-bit X and Z multiplexer outputs plus the registered carry-in. Computes Z ± (X + CIN) and drives P, PCOUT, CARRYOUT and CARRYOUTF. P feeds back to the Z multiplexer for accumulate operation.

## Interface
- PREG, 1, 1 = P/PCOUT registered (CEP-gated); 0 = combinational pass-through
- CARRYOUTREG, 1, 1 = CARRYOUT/CARRYOUTF registered (CECARRYOUT-gated); 0 = combinational
- CLK  in  1  single clock, rising edge
- RST_N  in  1  synchronous active-low reset for P and carry-out registers
- x_in  in  48  X multiplexer output
- z_in  in  48  Z multiplexer output
- cin  in  1  carry-in, already registered/selected upstream
- sub  in  1  OPMODE[7]: 0 = add, 1 = subtract
- CEP  in  1  clock enable, P register
- CECARRYOUT  in  1  clock enable, carry-out register
- P  out  48  result; fed back to the Z mux accumulate input
- PCOUT  out  48  cascade copy of P, always identical to P
- CARRYOUT  out  1  carry/borrow out of bit 47
- CARRYOUTF  out  1  fabric copy of CARRYOUT, always identical

## Operation
- All arithmetic is 49-bit unsigned, zero-extended: xs = {0,x_in}, zs = {0,z_in}.
- Add: r = zs + xs + cin.
- Subtract: r = zs − (xs + cin), two's complement modulo 2^49.
- sum = r[47:0]; cout = r[48].
  - In subtract mode cout = 1 indicates a borrow, i.e. (x_in + cin) > z_in.
- PREG=1, on CLK rising edge:
  - RST_N=0: P_reg ← 0. Reset has priority over CEP.
  - else if CEP=1: P_reg ← sum.
  - else: hold.
- PREG=0: P = sum combinationally; RST_N and CEP have no effect on P.
- The carry-out path follows identical rules using CARRYOUTREG, CECARRYOUT and cout.
- PCOUT ≡ P and CARRYOUTF ≡ CARRYOUT at all times. Each pair is driven from one register or one net.
- Wrap-around: overflow beyond 48 bits discards the sum bits above 47; bit 48 survives only as cout. No saturation.
- Accumulate loop: when the upstream Z mux selects P, the loop is closed through P_reg. PREG=0 with Z=P forms a combinational loop and is an illegal configuration. The bench does not exercise it.

## Timing
- Reset values: P = 0, PCOUT = 0, CARRYOUT = 0, CARRYOUTF = 0 after any cycle with RST_N=0, for registered configurations.
- Latency:
  - PREG=1: one cycle from x_in/z_in/cin/sub to P.
  - PREG=0: zero cycles.
  - CARRYOUTREG follows the same rule independently.
- Reset asserted mid-accumulation clears P on that edge. The accumulation restarts from 0 on the first CEP edge after RST_N returns high.
- Simultaneous RST_N=0 and CEP=1: reset wins; P = 0.
- CEP low freezes P even while the inputs change. Deasserting CEP during an accumulate loop holds the running total.
- P and CARRYOUT always update together from the same edge when both enables are high. They can diverge only when the enables differ.

## Structure
- Shared package dsp48a1_pkg:
  - DATA_W = 48.
  - Opmode bit index constant OPM_SUB = 7.
  - 48-bit data typedef, shared with the X/Z multiplexers.
- One sub-module, reg_ce_rst: parameterized width and REG bypass, sync active-low reset, clock enable.
  - Instantiated twice: 48-bit for P, 1-bit for carry-out.
  - The same primitive serves the other pipeline registers in the slice.
- Adder logic stays in the top-level module as a single 49-bit expression selected by sub.

## Test plan
- Reset (PREG=1): RST_N=0 for 2 cycles with CEP=1 and x=5, z=7 → P=0, CARRYOUT=0. Release → next edge P=12.
- Add with carry: x=48'h0000_0000_0001, z=48'hFFFF_FFFF_FFFF, cin=0, sub=0 → P=0, CARRYOUT=1, one cycle later.
- Subtract/borrow: z=10, x=3, cin=1, sub=1 → P=6, CARRYOUT=0. Then z=3, x=10, cin=0 → P=48'hFFFF_FFFF_FFF9, CARRYOUT=1.
- Accumulate with enable: Z mux fed from P, x=4, cin=0, add.
  - CEP high for 5 cycles → P = 4, 8, 12, 16, 20.
  - CEP low 3 cycles → P holds 20.
  - RST_N low 1 cycle → P=0.
- Reset vs enable: RST_N=0 and CEP=1 on the same edge with x=9, z=9 → P=0.
- Bypass (PREG=0, CARRYOUTREG=0): x=100, z=50, sub=0 → P=150 in the same cycle. Toggling RST_N and CEP has no effect.
- Both bypass configurations: check PCOUT==P and CARRYOUTF==CARRYOUT every cycle.
